// File: rtl/pyjamask96_host_if.sv
// Bridges a parallel block/key request to the byte-serial Pyjamask-96 core and returns the 96-bit result.
// Optional response watchdog: define PYJAMASK96_HOST_TIMEOUT_EN.
module pyjamask96_host_if #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [95:0]  blk_data,
  input  logic [127:0] blk_key,
  output logic         core_load,
  output logic         core_start,
  output logic [7:0]   core_byte_in,
  output logic [7:0]   core_byte_key_in,
  input  logic         core_valid,
  input  logic [7:0]   core_byte_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [95:0]  res_data,
  output logic         busy,
  output logic         timeout_err
);
  localparam int unsigned BLK_W     = 96;
  localparam int unsigned KEY_W     = 128;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CNT4_W    = 4;
  localparam int unsigned SEND_LAST = 15;
  localparam int unsigned RES_BYTES = 12;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_START, S_WAIT, S_COLLECT, S_RESULT
  } state_t;

  state_t              state, state_d;
  logic [BLK_W-1:0]    blk_sr, blk_sr_d;
  logic [KEY_W-1:0]    key_sr, key_sr_d;
  logic [BLK_W-1:0]    res_sr, res_sr_d;
  logic [CNT4_W-1:0]   send_cnt, send_cnt_d;
  logic [CNT4_W-1:0]   rx_cnt, rx_cnt_d;
  logic                tmo_d;

  logic                blk_ready_d, core_load_d, core_start_d;
  logic                res_valid_d, busy_d, timeout_err_d;
  logic [BYTE_W-1:0]   core_byte_in_d, core_byte_key_in_d;
  logic [BLK_W-1:0]    res_data_d;

`ifdef PYJAMASK96_HOST_TIMEOUT_EN
  logic [CNT_W-1:0] wdog, wdog_d;
  logic             wdog_exp;

  // Counts silent cycles while awaiting core bytes; restarts on every captured byte.
  always_comb begin
    wdog_d   = '0;
    wdog_exp = 1'b0;
    if ((state == S_WAIT || state == S_COLLECT) && !core_valid) begin
      wdog_d   = wdog + CNT_W'(1);
      wdog_exp = (wdog_d == CNT_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wdog <= '0;
    else          wdog <= wdog_d;
  end
`else
  logic wdog_exp;
  logic unused_cfg;
  assign wdog_exp   = 1'b0;
  assign unused_cfg = ^CNT_W'(TIMEOUT_CYCLES);
`endif

  // State and datapath register; outputs are registered from their next values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      blk_sr           <= '0;
      key_sr           <= '0;
      res_sr           <= '0;
      send_cnt         <= '0;
      rx_cnt           <= '0;
      blk_ready        <= 1'b0;
      core_load        <= 1'b0;
      core_start       <= 1'b0;
      core_byte_in     <= '0;
      core_byte_key_in <= '0;
      res_valid        <= 1'b0;
      res_data         <= '0;
      busy             <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      state            <= state_d;
      blk_sr           <= blk_sr_d;
      key_sr           <= key_sr_d;
      res_sr           <= res_sr_d;
      send_cnt         <= send_cnt_d;
      rx_cnt           <= rx_cnt_d;
      blk_ready        <= blk_ready_d;
      core_load        <= core_load_d;
      core_start       <= core_start_d;
      core_byte_in     <= core_byte_in_d;
      core_byte_key_in <= core_byte_key_in_d;
      res_valid        <= res_valid_d;
      res_data         <= res_data_d;
      busy             <= busy_d;
      timeout_err      <= timeout_err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state;
    blk_sr_d   = blk_sr;
    key_sr_d   = key_sr;
    res_sr_d   = res_sr;
    send_cnt_d = send_cnt;
    rx_cnt_d   = rx_cnt;
    tmo_d      = 1'b0;
    case (state)
      S_IDLE: begin
        if (blk_valid && blk_ready) begin
          blk_sr_d   = blk_data;
          key_sr_d   = blk_key;
          send_cnt_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        blk_sr_d   = {blk_sr[BLK_W-BYTE_W-1:0], BYTE_W'(0)};
        key_sr_d   = {key_sr[KEY_W-BYTE_W-1:0], BYTE_W'(0)};
        send_cnt_d = send_cnt + CNT4_W'(1);
        if (send_cnt == CNT4_W'(SEND_LAST)) state_d = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (core_valid) begin
          res_sr_d = {res_sr[BLK_W-BYTE_W-1:0], core_byte_out};
          rx_cnt_d = CNT4_W'(1);
          state_d  = S_COLLECT;
        end else if (wdog_exp) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (core_valid) begin
          res_sr_d = {res_sr[BLK_W-BYTE_W-1:0], core_byte_out};
          rx_cnt_d = rx_cnt + CNT4_W'(1);
          if (rx_cnt == CNT4_W'(RES_BYTES - 1)) state_d = S_RESULT;
        end else if (wdog_exp) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RESULT: begin
        if (res_valid && res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so every output leaves a flop.
  always_comb begin
    blk_ready_d        = (state_d == S_IDLE);
    core_load_d        = (state_d == S_SEND) && (send_cnt_d == '0);
    core_start_d       = (state_d == S_START);
    core_byte_in_d     = '0;
    core_byte_key_in_d = '0;
    if (state_d == S_SEND) begin
      core_byte_in_d     = blk_sr_d[BLK_W-1 -: BYTE_W];
      core_byte_key_in_d = key_sr_d[KEY_W-1 -: BYTE_W];
    end
    res_valid_d   = (state_d == S_RESULT);
    res_data_d    = (state_d == S_RESULT) ? res_sr_d : '0;
    busy_d        = (state_d != S_IDLE);
    timeout_err_d = tmo_d;
  end

endmodule
